frame_sync_ctrl: RTL and testbench

- Serial frame-sync controller built around a non-overlapping sync-word detector (default 1010).
- Hunts a serial bit stream for SYNC_PATTERN, then captures the next PAYLOAD_W bits as one frame.
- Presents each frame on a valid/ready output with a single-entry buffer, then re-enters hunt.
- Sits between a serial line receiver and any downstream parallel consumer.

---
 rtl/frame_sync_ctrl.sv | 167 ++++++++++++++++
 tb/tb_frame_sync_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sync_ctrl.sv
// frame_sync_ctrl: serial frame-sync controller.
// Hunts the bit stream for a non-overlapping sync word, then captures the
// following PAYLOAD_W bits into a single-entry valid/ready output buffer.
module frame_sync_ctrl #(
    parameter int                SYNC_W       = 4,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1010,
    parameter int                PAYLOAD_W    = 8,
    parameter int                CNT_W        = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sync_found,
    output logic                 busy,
    output logic                 drop,
    output logic [CNT_W-1:0]     frame_count,
    output logic [CNT_W-1:0]     drop_count
);

    localparam int FILL_W = $clog2(SYNC_W + 1);
    localparam int BC_W   = $clog2(PAYLOAD_W + 1);

    typedef enum logic {
        HUNT,
        CAPTURE
    } state_t;

    state_t                state;
    state_t                state_nxt;

    // Only the older SYNC_W-1 / PAYLOAD_W-1 bits are stored; the current
    // bit_in completes the word combinationally.
    logic [SYNC_W-2:0]     hist;
    logic [SYNC_W-1:0]     hist_shift;
    logic [FILL_W-1:0]     fill;
    logic [BC_W-1:0]       bit_cnt;
    logic [PAYLOAD_W-2:0]  pay_sr;
    logic [PAYLOAD_W-1:0]  pay_shift;

    logic                  accept;
    logic                  match;
    logic                  frame_done;
    logic                  can_load;

    // Decode accepted bits, sync match, and frame completion
    always_comb begin
        accept     = en & bit_valid;
        hist_shift = {hist, bit_in};
        pay_shift  = {pay_sr, bit_in};
        match      = (state == HUNT) && accept &&
                     (hist_shift == SYNC_PATTERN) &&
                     (fill >= FILL_W'(SYNC_W - 1));
        frame_done = (state == CAPTURE) && accept &&
                     (bit_cnt == BC_W'(PAYLOAD_W - 1));
        can_load   = !out_valid || out_ready;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; en low forces hunt
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = HUNT;
        end else begin
            case (state)
                HUNT:    if (match)      state_nxt = CAPTURE;
                CAPTURE: if (frame_done) state_nxt = HUNT;
                default:                 state_nxt = HUNT;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        busy = (state == CAPTURE);
    end

    // Hunt history, fill counter, payload shift register and bit counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist    <= '0;
            fill    <= '0;
            bit_cnt <= '0;
            pay_sr  <= '0;
        end else if (!en) begin
            hist    <= '0;
            fill    <= '0;
            bit_cnt <= '0;
        end else if (state == HUNT) begin
            if (accept) begin
                if (match) begin
                    // sync bits are consumed; the next hunt starts empty
                    hist    <= '0;
                    fill    <= '0;
                    bit_cnt <= '0;
                end else begin
                    hist <= hist_shift[SYNC_W-2:0];
                    if (fill != FILL_W'(SYNC_W)) begin
                        fill <= fill + FILL_W'(1);
                    end
                end
            end
        end else begin
            if (accept) begin
                pay_sr <= pay_shift[PAYLOAD_W-2:0];
                if (frame_done) begin
                    bit_cnt <= '0;
                    hist    <= '0;
                    fill    <= '0;
                end else begin
                    bit_cnt <= bit_cnt + BC_W'(1);
                end
            end
        end
    end

    // One-cycle sync pulse following the final sync bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_found <= 1'b0;
        end else begin
            sync_found <= match;
        end
    end

    // Output buffer, handshake, drop pulse and counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data    <= '0;
            out_valid   <= 1'b0;
            drop        <= 1'b0;
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            drop <= 1'b0;
            if (frame_done && can_load) begin
                out_data    <= pay_shift;
                out_valid   <= 1'b1;
                frame_count <= frame_count + CNT_W'(1);
            end else begin
                if (frame_done) begin
                    drop <= 1'b1;
                    if (drop_count != '1) begin
                        drop_count <= drop_count + CNT_W'(1);
                    end
                end
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// tb_frame_sync_ctrl: directed self-checking bench for frame_sync_ctrl.
module tb_frame_sync_ctrl;

    logic       clk;
    logic       reset;
    logic       en;
    logic       bit_in;
    logic       bit_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       sync_found;
    logic       busy;
    logic       drop;
    logic [7:0] frame_count;
    logic [7:0] drop_count;

    int tests_run = 0;
    int failures  = 0;

    frame_sync_ctrl #(
        .SYNC_W       (4),
        .SYNC_PATTERN (4'b1010),
        .PAYLOAD_W    (8),
        .CNT_W        (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sync_found  (sync_found),
        .busy        (busy),
        .drop        (drop),
        .frame_count (frame_count),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_sync();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        en        = 1'b1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle(1);
        tests_run++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests_run++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        tests_run++; if (sync_found !== 1'b0) begin failures++; $display("FAIL reset_sync_found: got %b expected 0", sync_found); end
        tests_run++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (drop !== 1'b0) begin failures++; $display("FAIL reset_drop: got %b expected 0", drop); end
        tests_run++; if (frame_count !== 8'd0) begin failures++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count); end
        tests_run++; if (drop_count !== 8'd0) begin failures++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
        reset = 1'b1;
        idle(1);
    endtask

    task automatic test_basic_frame();
        apply_reset();
        out_ready = 1'b1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        tests_run++; if (sync_found !== 1'b0) begin failures++; $display("FAIL basic_early_sync: got %b expected 0", sync_found); end
        send_bit(1'b0);
        tests_run++; if (sync_found !== 1'b1) begin failures++; $display("FAIL basic_sync_pulse: got %b expected 1", sync_found); end
        tests_run++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b expected 1", busy); end
        send_byte(8'hC3);
        tests_run++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
        tests_run++; if (out_data !== 8'hC3) begin failures++; $display("FAIL basic_out_data: got %h expected c3", out_data); end
        tests_run++; if (frame_count !== 8'd1) begin failures++; $display("FAIL basic_frame_count: got %0d expected 1", frame_count); end
        tests_run++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
        idle(1);
        tests_run++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_out_valid_clear: got %b expected 0", out_valid); end
    endtask

    task automatic test_late_match();
        apply_reset();
        out_ready = 1'b1;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        tests_run++; if (sync_found !== 1'b0) begin failures++; $display("FAIL late_no_match_bit4: got %b expected 0", sync_found); end
        send_bit(1'b0);
        tests_run++; if (sync_found !== 1'b1) begin failures++; $display("FAIL late_match_bit5: got %b expected 1", sync_found); end
        send_byte(8'hA5);
        tests_run++; if (out_data !== 8'hA5) begin failures++; $display("FAIL late_out_data: got %h expected a5", out_data); end
    endtask

    task automatic test_non_overlap();
        int syncs;
        logic [11:0] v;
        apply_reset();
        out_ready = 1'b1;
        syncs = 0;
        v = 12'b1010_1010_1111;
        for (int i = 11; i >= 0; i--) begin
            send_bit(v[i]);
            if (sync_found === 1'b1) syncs++;
        end
        tests_run++; if (out_data !== 8'hAF) begin failures++; $display("FAIL overlap_out_data: got %h expected af", out_data); end
        send_bit(1'b1);
        if (sync_found === 1'b1) syncs++;
        send_bit(1'b0);
        if (sync_found === 1'b1) syncs++;
        idle(1);
        if (sync_found === 1'b1) syncs++;
        tests_run++; if (syncs !== 1) begin failures++; $display("FAIL overlap_sync_count: got %0d expected 1", syncs); end
        tests_run++; if (busy !== 1'b0) begin failures++; $display("FAIL overlap_busy: got %b expected 0", busy); end
    endtask

    task automatic test_drop();
        apply_reset();
        out_ready = 1'b0;
        send_sync(); send_byte(8'h11);
        tests_run++; if (out_valid !== 1'b1) begin failures++; $display("FAIL drop_first_valid: got %b expected 1", out_valid); end
        send_sync(); send_byte(8'h22);
        tests_run++; if (drop !== 1'b1) begin failures++; $display("FAIL drop_pulse: got %b expected 1", drop); end
        tests_run++; if (out_data !== 8'h11) begin failures++; $display("FAIL drop_out_data_held: got %h expected 11", out_data); end
        tests_run++; if (drop_count !== 8'd1) begin failures++; $display("FAIL drop_drop_count: got %0d expected 1", drop_count); end
        tests_run++; if (frame_count !== 8'd1) begin failures++; $display("FAIL drop_frame_count: got %0d expected 1", frame_count); end
        idle(1);
        tests_run++; if (drop !== 1'b0) begin failures++; $display("FAIL drop_pulse_width: got %b expected 0", drop); end
        tests_run++; if (out_valid !== 1'b1) begin failures++; $display("FAIL drop_valid_held: got %b expected 1", out_valid); end
        out_ready = 1'b1;
        idle(1);
        tests_run++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drop_handshake_clear: got %b expected 0", out_valid); end
        tests_run++; if (frame_count !== 8'd1) begin failures++; $display("FAIL drop_frame_count_end: got %0d expected 1", frame_count); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        out_ready = 1'b0;
        send_sync(); send_byte(8'h11);
        send_sync();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        out_ready = 1'b1;
        send_bit(1'b0);
        tests_run++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid: got %b expected 1", out_valid); end
        tests_run++; if (out_data !== 8'h66) begin failures++; $display("FAIL b2b_data: got %h expected 66", out_data); end
        tests_run++; if (drop !== 1'b0) begin failures++; $display("FAIL b2b_no_drop: got %b expected 0", drop); end
        tests_run++; if (frame_count !== 8'd2) begin failures++; $display("FAIL b2b_frame_count: got %0d expected 2", frame_count); end
        idle(1);
        tests_run++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_clear: got %b expected 0", out_valid); end
    endtask

    task automatic test_gaps();
        logic [11:0] v;
        apply_reset();
        out_ready = 1'b0;
        v = {4'b1010, 8'h5A};
        for (int i = 11; i >= 0; i--) begin
            idle(3);
            send_bit(v[i]);
            if (i == 8) begin
                tests_run++; if (sync_found !== 1'b1) begin failures++; $display("FAIL gap_sync_pulse: got %b expected 1", sync_found); end
                idle(1);
                tests_run++; if (sync_found !== 1'b0) begin failures++; $display("FAIL gap_sync_width: got %b expected 0", sync_found); end
            end
            if (i == 1) begin
                idle(3);
                tests_run++; if (out_valid !== 1'b0) begin failures++; $display("FAIL gap_early_valid: got %b expected 0", out_valid); end
                tests_run++; if (busy !== 1'b1) begin failures++; $display("FAIL gap_busy_frozen: got %b expected 1", busy); end
            end
        end
        tests_run++; if (out_valid !== 1'b1) begin failures++; $display("FAIL gap_valid: got %b expected 1", out_valid); end
        tests_run++; if (out_data !== 8'h5A) begin failures++; $display("FAIL gap_data: got %h expected 5a", out_data); end
    endtask

    task automatic test_enable_abort();
        apply_reset();
        out_ready = 1'b1;
        send_sync();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        en = 1'b0;
        idle(1);
        tests_run++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
        en = 1'b1;
        send_sync(); send_byte(8'h3C);
        tests_run++; if (out_data !== 8'h3C) begin failures++; $display("FAIL abort_out_data: got %h expected 3c", out_data); end
        tests_run++; if (frame_count !== 8'd1) begin failures++; $display("FAIL abort_frame_count: got %0d expected 1", frame_count); end
        tests_run++; if (drop_count !== 8'd0) begin failures++; $display("FAIL abort_drop_count: got %0d expected 0", drop_count); end
        idle(1);
        send_sync();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        reset = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        tests_run++; if (out_data !== 8'h00) begin failures++; $display("FAIL midreset_out_data: got %h expected 00", out_data); end
        tests_run++; if (frame_count !== 8'd0) begin failures++; $display("FAIL midreset_frame_count: got %0d expected 0", frame_count); end
        idle(1);
        reset = 1'b1;
        idle(1);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        tests_run++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_no_output: got %b expected 0", out_valid); end
    endtask

    task automatic test_drop_saturate();
        apply_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 260; i++) begin
            send_sync();
            send_byte(8'(i + 1));
        end
        tests_run++; if (drop_count !== 8'hFF) begin failures++; $display("FAIL sat_drop_count: got %0d expected 255", drop_count); end
        tests_run++; if (frame_count !== 8'd1) begin failures++; $display("FAIL sat_frame_count: got %0d expected 1", frame_count); end
        tests_run++; if (out_data !== 8'h01) begin failures++; $display("FAIL sat_out_data: got %h expected 01", out_data); end
    endtask

    initial begin
        reset     = 1'b0;
        en        = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic_frame();
        test_late_match();
        test_non_overlap();
        test_drop();
        test_back_to_back();
        test_gaps();
        test_enable_abort();
        test_drop_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
